// File: rtl/count_load_sequencer.sv
// Period feeder for an n-bit parallel-load counter: 2-entry FIFO, shadow down-count, load/tc strobes.
// Optional macro SEQ_AUTO_RELOAD_EN: on terminal count with an empty FIFO, reload the last value instead of idling.
module count_load_sequencer #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] in_data,
   input  logic         cnt_en,
   output logic         load_o,
   output logic [n-1:0] load_val,
   output logic         tc_o,
   output logic         busy,
   output logic [1:0]   fifo_level
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t       state, state_nxt;
   logic [n-1:0] remaining, remaining_nxt, load_val_nxt;
   logic         tc_nxt;
   logic         push, pop;
   logic [n-1:0] fifo_mem [2];

   // Ready depends only on the registered level, never on in_valid.
   assign in_ready = reset_n && (fifo_level != 2'd2);
   assign push     = in_valid && in_ready;
   assign load_o   = (state == LOAD);
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      load_val_nxt  = load_val;
      tc_nxt        = 1'b0;
      pop           = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_level != 2'd0) begin
               pop           = 1'b1;
               load_val_nxt  = fifo_mem[0];
               remaining_nxt = fifo_mem[0];
               state_nxt     = LOAD;
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            if (cnt_en) begin
               if (remaining != '0) begin
                  remaining_nxt = remaining - 1'b1;
               end else begin
                  tc_nxt = 1'b1;
                  if (fifo_level != 2'd0) begin
                     pop           = 1'b1;
                     load_val_nxt  = fifo_mem[0];
                     remaining_nxt = fifo_mem[0];
                     state_nxt     = LOAD;
                  end else begin
`ifdef SEQ_AUTO_RELOAD_EN
                     remaining_nxt = load_val;
                     state_nxt     = LOAD;
`else
                     state_nxt     = IDLE;
`endif
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         remaining  <= '0;
         load_val   <= '0;
         tc_o       <= 1'b0;
         fifo_level <= 2'd0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         load_val  <= load_val_nxt;
         tc_o      <= tc_nxt;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 2'd1;
            2'b01:   fifo_level <= fifo_level - 2'd1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Head always sits in slot 0; a pop shifts slot 1 forward.
   always_ff @(posedge clk) begin
      if (push && pop) begin
         if (fifo_level == 2'd1) begin
            fifo_mem[0] <= in_data;
         end else begin
            fifo_mem[0] <= fifo_mem[1];
            fifo_mem[1] <= in_data;
         end
      end else if (pop) begin
         fifo_mem[0] <= fifo_mem[1];
      end else if (push) begin
         fifo_mem[fifo_level[0]] <= in_data;
      end
   end

endmodule

// File: tb/tb_count_load_sequencer.sv
// Directed bench for count_load_sequencer; scenarios run in sequence, one task each.
module tb_count_load_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       cnt_en;
   logic       load_o;
   logic [3:0] load_val;
   logic       tc_o;
   logic       busy;
   logic [1:0] fifo_level;

   int n_cmp = 0;
   int n_bad = 0;

   count_load_sequencer #(.n(4)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .cnt_en(cnt_en), .load_o(load_o), .load_val(load_val),
      .tc_o(tc_o), .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'd0;
      cnt_en   = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'd7;
      cnt_en   = 1'b1;
      step();
      step();
      n_cmp++; if (load_o !== 1'b0)     begin n_bad++; $display("FAIL rst_load_o got %b exp 0", load_o); end
      n_cmp++; if (load_val !== 4'd0)   begin n_bad++; $display("FAIL rst_load_val got %0d exp 0", load_val); end
      n_cmp++; if (tc_o !== 1'b0)       begin n_bad++; $display("FAIL rst_tc_o got %b exp 0", tc_o); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (fifo_level !== 2'd0) begin n_bad++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      in_valid = 1'b0;
      cnt_en   = 1'b0;
      reset_n  = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
      step();
      n_cmp++; if (fifo_level !== 2'd0) begin n_bad++; $display("FAIL rel_level got %0d exp 0", fifo_level); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rel_busy got %b exp 0", busy); end
   endtask

   task automatic test_single_period();
      do_reset();
      in_valid = 1'b1;
      in_data  = 4'd3;
      cnt_en   = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++; if (fifo_level !== 2'd1) begin n_bad++; $display("FAIL sp_level got %0d exp 1", fifo_level); end
      step();
      n_cmp++; if (load_o !== 1'b1)     begin n_bad++; $display("FAIL sp_load_o got %b exp 1", load_o); end
      n_cmp++; if (load_val !== 4'd3)   begin n_bad++; $display("FAIL sp_load_val got %0d exp 3", load_val); end
      n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL sp_busy got %b exp 1", busy); end
      n_cmp++; if (fifo_level !== 2'd0) begin n_bad++; $display("FAIL sp_level0 got %0d exp 0", fifo_level); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (tc_o !== 1'b0 || load_o !== 1'b0)
            begin n_bad++; $display("FAIL sp_run%0d tc=%b load=%b exp 0 0", i, tc_o, load_o); end
      end
      step();
      n_cmp++; if (tc_o !== 1'b1) begin n_bad++; $display("FAIL sp_tc got %b exp 1", tc_o); end
`ifdef SEQ_AUTO_RELOAD_EN
      n_cmp++; if (load_o !== 1'b1 || busy !== 1'b1 || load_val !== 4'd3)
         begin n_bad++; $display("FAIL sp_reload load=%b busy=%b val=%0d exp 1 1 3", load_o, busy, load_val); end
`else
      n_cmp++; if (load_o !== 1'b0 || busy !== 1'b0)
         begin n_bad++; $display("FAIL sp_end load=%b busy=%b exp 0 0", load_o, busy); end
      step();
      n_cmp++; if (tc_o !== 1'b0 || busy !== 1'b0 || load_val !== 4'd3)
         begin n_bad++; $display("FAIL sp_idle tc=%b busy=%b val=%0d exp 0 0 3", tc_o, busy, load_val); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_vals [3];
      int ld;
      int tcn;
      exp_vals[0] = 4'd2;
      exp_vals[1] = 4'd5;
      exp_vals[2] = 4'd1;
      ld  = 0;
      tcn = 0;
      do_reset();
      cnt_en = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         case (cyc)
            0: begin in_valid = 1'b1; in_data = 4'd2; end
            1: begin in_valid = 1'b1; in_data = 4'd5; end
            2: begin in_valid = 1'b1; in_data = 4'd1; end
            3: begin in_valid = 1'b1; in_data = 4'd9; end
            default: in_valid = 1'b0;
         endcase
         step();
         if (cyc == 2 || cyc == 3) begin
            n_cmp++; if (fifo_level !== 2'd2 || in_ready !== 1'b0)
               begin n_bad++; $display("FAIL b2b_full%0d level=%0d ready=%b exp 2 0", cyc, fifo_level, in_ready); end
         end
         if (load_o === 1'b1) begin
            if (ld < 3) begin
               n_cmp++; if (load_val !== exp_vals[ld])
                  begin n_bad++; $display("FAIL b2b_order%0d got %0d exp %0d", ld, load_val, exp_vals[ld]); end
            end
            ld++;
         end
         if (tc_o === 1'b1) begin
            if (tcn < 2) begin
               n_cmp++; if (load_o !== 1'b1)
                  begin n_bad++; $display("FAIL b2b_tc_load%0d got %b exp 1", tcn, load_o); end
            end
            tcn++;
         end
      end
`ifndef SEQ_AUTO_RELOAD_EN
      n_cmp++; if (ld !== 3)  begin n_bad++; $display("FAIL b2b_loads got %0d exp 3", ld); end
      n_cmp++; if (tcn !== 3) begin n_bad++; $display("FAIL b2b_tcs got %0d exp 3", tcn); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle busy=%b exp 0", busy); end
`endif
   endtask

   task automatic test_cnt_en_gate();
      logic en_pat [8];
      en_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      in_data = 4'd2;
      for (int e = 0; e < 8; e++) begin
         in_valid = (e == 0);
         cnt_en   = en_pat[e];
         step();
         if (e < 7) begin
            n_cmp++; if (tc_o !== 1'b0) begin n_bad++; $display("FAIL gate_tc%0d got %b exp 0", e, tc_o); end
         end else begin
            n_cmp++; if (tc_o !== 1'b1) begin n_bad++; $display("FAIL gate_tc%0d got %b exp 1", e, tc_o); end
         end
      end
      cnt_en = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      cnt_en   = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd3;
      step();
      in_data  = 4'd4;
      step();
      in_valid = 1'b0;
      step();
      step();
      n_cmp++; if (fifo_level !== 2'd1 || busy !== 1'b1)
         begin n_bad++; $display("FAIL mid_pre level=%0d busy=%b exp 1 1", fifo_level, busy); end
      reset_n = 1'b0;
      step();
      n_cmp++; if (fifo_level !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b0)
         begin n_bad++; $display("FAIL mid_rst level=%0d busy=%b ready=%b exp 0 0 0", fifo_level, busy, in_ready); end
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++; if (tc_o !== 1'b0 || load_o !== 1'b0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL mid_after%0d tc=%b load=%b busy=%b exp 0 0 0", i, tc_o, load_o, busy); end
      end
   endtask

`ifdef SEQ_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      do_reset();
      cnt_en   = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd1;
      step();
      in_valid = 1'b0;
      for (int i = 2; i < 16; i++) begin
         step();
         n_cmp++; if (load_o !== (((i - 2) % 3) == 0) || tc_o !== ((i >= 5) && (((i - 2) % 3) == 0)))
            begin n_bad++; $display("FAIL auto%0d load=%b tc=%b", i, load_o, tc_o); end
         n_cmp++; if (load_val !== 4'd1)
            begin n_bad++; $display("FAIL auto_val%0d got %0d exp 1", i, load_val); end
      end
   endtask
`endif

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'd0;
      cnt_en   = 1'b0;
      test_reset();
      test_single_period();
      test_back_to_back();
      test_cnt_en_gate();
      test_reset_mid_run();
`ifdef SEQ_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
